// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma -- OAM DMA engine and bus arbiter between the 6502 core and the
// system bus.
//
// In normal operation the CPU owns the bus: its address, data and strobes
// pass straight through. A CPU write to DMA_REG latches the source page and
// halts the CPU by dropping cpu_ce. The engine then copies 256 bytes from
// {page,00..FF} to OAM_DATA with alternating read and write bus cycles.
// When the copy ends, bus ownership returns to the CPU.
//
// Ports:
//   clock    in   system clock
//   reset_n  in   synchronous active-low reset
//   tick     in   CPU cycle strobe; all state advances only when tick=1
//   cpu_a    in   CPU address
//   cpu_d    in   CPU write data
//   cpu_r    in   CPU read strobe
//   cpu_w    in   CPU write strobe
//   cpu_ce   out  CPU clock-enable (tick while idle, 0 while copying)
//   bus_a    out  arbitrated bus address
//   bus_d    out  arbitrated bus write data
//   bus_r    out  arbitrated read strobe
//   bus_w    out  arbitrated write strobe
//   bus_i    in   bus read data, valid on the tick after a read cycle
//   busy     out  high whenever a DMA is in progress
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_r,
    input  logic        cpu_w,
    output logic        cpu_ce,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_d,
    output logic        bus_r,
    output logic        bus_w,
    input  logic [7:0]  bus_i,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        RD    = 3'd3,
        WR    = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  page_r;
    logic [7:0]  next_page_s;
    logic [7:0]  idx_r;
    logic [7:0]  next_idx_s;
    logic [7:0]  latch_r;
    logic [7:0]  next_latch_s;
    logic        parity_r;
    // Cycle parity at which the trigger write landed; steers HALT into ALIGN.
    logic        trig_parity_r;
    logic        next_trig_parity_s;

    // State and datapath registers; everything advances only on a CPU tick.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            page_r        <= 8'h00;
            idx_r         <= 8'h00;
            latch_r       <= 8'h00;
            parity_r      <= 1'b0;
            trig_parity_r <= 1'b0;
        end else if (tick) begin
            state_r       <= next_state_s;
            page_r        <= next_page_s;
            idx_r         <= next_idx_s;
            latch_r       <= next_latch_s;
            parity_r      <= ~parity_r;
            trig_parity_r <= next_trig_parity_s;
        end
    end

    // Next-state logic and bus arbitration outputs.
    always_comb begin
        next_state_s       = state_r;
        next_page_s        = page_r;
        next_idx_s         = idx_r;
        next_latch_s       = latch_r;
        next_trig_parity_s = trig_parity_r;

        cpu_ce = tick & (state_r == IDLE);
        busy   = (state_r != IDLE);
        bus_a  = cpu_a;
        bus_d  = latch_r;
        bus_r  = 1'b0;
        bus_w  = 1'b0;

        case (state_r)
            IDLE: begin
                // CPU owns the bus; the trigger write itself still goes out.
                bus_d = cpu_d;
                bus_r = cpu_r;
                bus_w = cpu_w;
                if (cpu_w && (cpu_a == DMA_REG)) begin
                    next_page_s        = cpu_d;
                    next_idx_s         = 8'h00;
                    next_trig_parity_s = parity_r;
                    next_state_s       = HALT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            HALT: begin
                // A trigger landing on an odd cycle needs one extra
                // alignment cycle before the read/write pairs start.
                if (trig_parity_r) begin
                    next_state_s = ALIGN;
                end else begin
                    next_state_s = RD;
                end
            end
            ALIGN: begin
                next_state_s = RD;
            end
            RD: begin
                bus_a        = {page_r, idx_r};
                bus_r        = 1'b1;
                next_state_s = WR;
            end
            WR: begin
                // Read data is forwarded straight to OAM in the same cycle.
                bus_a        = OAM_DATA;
                bus_d        = bus_i;
                bus_w        = 1'b1;
                next_latch_s = bus_i;
                next_idx_s   = idx_r + 8'd1;
                if (idx_r == 8'hFF) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RD;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma -- directed self-checking bench for oam_dma.
// A small bus memory returns mem_byte(addr) on the tick after each read;
// a monitor logs every read address and every write to 2004 so the main
// sequence can compare them against the expected copy.
// ---------------------------------------------------------------------------
module tb_oam_dma;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        tick;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_r;
    logic        cpu_w;
    logic        cpu_ce;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_r;
    logic        bus_w;
    logic [7:0]  bus_i;
    logic        busy;

    logic [7:0]  rd_q = 8'h00;
    assign bus_i = rd_q;

    oam_dma dut (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick),
        .cpu_a   (cpu_a),
        .cpu_d   (cpu_d),
        .cpu_r   (cpu_r),
        .cpu_w   (cpu_w),
        .cpu_ce  (cpu_ce),
        .bus_a   (bus_a),
        .bus_d   (bus_d),
        .bus_r   (bus_r),
        .bus_w   (bus_w),
        .bus_i   (bus_i),
        .busy    (busy)
    );

    always #20 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    int tick_no, wr_cnt, rd_cnt, stall_cnt, trig_tick, first_rd_tick;
    int zero_hit, ce_bad, trig_seen, hold_err;
    bit gap = 1'b0;
    logic [15:0] rd_log [256];
    logic [7:0]  wr_log [256];

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // Bus memory and transaction monitor, active on tick edges out of reset.
    always @(posedge clock) begin
        if (reset_n && tick) begin
            tick_no <= tick_no + 1;
            if (bus_r) begin
                rd_q <= mem_byte(bus_a);
                if (rd_cnt < 256) rd_log[rd_cnt] <= bus_a;
                if (rd_cnt == 0) first_rd_tick <= tick_no;
                rd_cnt <= rd_cnt + 1;
                if (bus_a == 16'h0000) zero_hit <= zero_hit + 1;
            end
            if (bus_w && bus_a == 16'h2004) begin
                if (wr_cnt < 256) wr_log[wr_cnt] <= bus_d;
                wr_cnt <= wr_cnt + 1;
            end
            if (bus_w && bus_a == 16'h4014) begin
                trig_seen <= trig_seen + 1;
                trig_tick <= tick_no;
            end
            if (busy) begin
                stall_cnt <= stall_cnt + 1;
                if (cpu_ce) ce_bad <= ce_bad + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_cnt = 0; rd_cnt = 0; stall_cnt = 0; trig_tick = 0; first_rd_tick = 0;
        zero_hit = 0; ce_bad = 0; trig_seen = 0; hold_err = 0;
    endtask

    task automatic do_clock();
        @(posedge clock);
        #1;
    endtask

    // One CPU tick; in gapped mode followed by two idle clocks that must not
    // disturb any output.
    task automatic step();
        logic [26:0] snap;
        tick = 1'b1;
        do_clock();
        tick = 1'b0;
        if (gap) begin
            #1;
            snap = {busy, bus_a, bus_d, bus_r, bus_w};
            do_clock();
            do_clock();
            if ({busy, bus_a, bus_d, bus_r, bus_w} !== snap) hold_err++;
        end
    endtask

    task automatic align_parity(input int want);
        if ((tick_no % 2) != want) step();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_a = a; cpu_d = d; cpu_w = 1'b1;
        step();
        cpu_w = 1'b0; cpu_a = 16'h8000; cpu_d = 8'h00;
    endtask

    task automatic run_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_copy(input string tag, input logic [7:0] page,
                              input int exp_stall, input int exp_first);
        int err;
        err = 0;
        chk({tag, "_stall"}, stall_cnt, exp_stall);
        chk({tag, "_writes"}, wr_cnt, 32'd256);
        chk({tag, "_reads"}, rd_cnt, 32'd256);
        chk({tag, "_trig_on_bus"}, trig_seen, 32'd1);
        chk({tag, "_first_rd"}, first_rd_tick - trig_tick, exp_first);
        chk({tag, "_ce_busy"}, ce_bad, 32'd0);
        for (int i = 0; i < 256; i++) begin
            if (rd_log[i] !== {page, 8'(i)}) err++;
            if (wr_log[i] !== mem_byte({page, 8'(i)})) err++;
        end
        chk({tag, "_data"}, err, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; tick = 1'b0;
        cpu_a = 16'h8000; cpu_d = 8'h00; cpu_r = 1'b0; cpu_w = 1'b0;
        tick_no = 0;
        clear_logs();
        do_clock();
        do_clock();
        reset_n = 1'b1;

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ce_tick0", {31'd0, cpu_ce}, 32'd0);
        chk("rst_idx", {24'd0, dut.idx_r}, 32'd0);
        chk("rst_page", {24'd0, dut.page_r}, 32'd0);
        tick = 1'b1; #1;
        chk("rst_ce_tick1", {31'd0, cpu_ce}, 32'd1);
        tick = 1'b0; #1;

        // Non-trigger writes pass through unchanged
        cpu_a = 16'h4015; cpu_d = 8'h33; cpu_w = 1'b1; #1;
        chk("pass_a", {16'd0, bus_a}, 32'h4015);
        chk("pass_d", {24'd0, bus_d}, 32'h33);
        chk("pass_w", {30'd0, bus_r, bus_w}, 32'h1);
        step();
        chk("pass_busy_4015", {31'd0, busy}, 32'd0);
        cpu_w = 1'b0; cpu_r = 1'b1; cpu_a = 16'h1234; #1;
        chk("pass_r", {14'd0, bus_r, bus_w, bus_a}, 32'h2_1234);
        cpu_r = 1'b0;
        clear_logs();
        cpu_write(16'h2004, 8'h99);
        chk("pass_2004_cnt", wr_cnt, 32'd1);
        chk("pass_2004_data", {24'd0, wr_log[0]}, 32'h99);
        chk("pass_busy_2004", {31'd0, busy}, 32'd0);

        // Even trigger, page 02; a stray write to DMA_REG while busy is ignored
        align_parity(0);
        clear_logs();
        cpu_write(16'h4014, 8'h02);
        chk("even_busy", {31'd0, busy}, 32'd1);
        tick = 1'b1; #1;
        chk("even_ce", {31'd0, cpu_ce}, 32'd0);
        tick = 1'b0;
        cpu_a = 16'h4014; cpu_d = 8'h55; cpu_w = 1'b1;
        run_idle("even", 600);
        cpu_w = 1'b0; cpu_a = 16'h8000; cpu_d = 8'h00;
        check_copy("even", 8'h02, 513, 2);

        // Odd trigger, page 07: one ALIGN cycle
        align_parity(1);
        clear_logs();
        cpu_write(16'h4014, 8'h07);
        run_idle("odd", 600);
        check_copy("odd", 8'h07, 514, 3);

        // Page FF: reads stop at FFFF, never wrap to 0000, idx returns to 0
        align_parity(0);
        clear_logs();
        cpu_write(16'h4014, 8'hFF);
        run_idle("pgff", 600);
        check_copy("pgff", 8'hFF, 513, 2);
        chk("pgff_last_rd", {16'd0, rd_log[255]}, 32'hFFFF);
        chk("pgff_zero_hit", zero_hit, 32'd0);
        chk("pgff_idx", {24'd0, dut.idx_r}, 32'd0);

        // Gapped tick: one tick every third clock
        gap = 1'b1;
        align_parity(0);
        clear_logs();
        cpu_write(16'h4014, 8'h02);
        run_idle("gap", 600);
        check_copy("gap", 8'h02, 513, 2);
        chk("gap_hold", hold_err, 32'd0);
        gap = 1'b0;

        // Reset after 100 bytes aborts the copy
        clear_logs();
        cpu_write(16'h4014, 8'h03);
        for (int n = 0; n < 1000 && wr_cnt < 100; n++) step();
        chk("rstmid_at100", wr_cnt, 32'd100);
        reset_n = 1'b0; tick = 1'b1;
        do_clock();
        reset_n = 1'b1; tick = 1'b0; tick_no = 0;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        tick = 1'b1; #1;
        chk("rstmid_ce", {31'd0, cpu_ce}, 32'd1);
        tick = 1'b0;
        for (int n = 0; n < 20; n++) step();
        chk("rstmid_no_more_wr", wr_cnt, 32'd100);
        chk("rstmid_busy_after", {31'd0, busy}, 32'd0);

        // Retrigger after the abort restarts from idx 0
        align_parity(0);
        clear_logs();
        cpu_write(16'h4014, 8'h04);
        run_idle("retrig", 600);
        check_copy("retrig", 8'h04, 513, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
